// File: rtl/pipe_stage_buf_pkg.sv
// Shared occupancy-state encoding and default widths for every pipe_stage_buf instance.
package pipe_stage_buf_pkg;

  localparam int unsigned PIPE_LANES_DEF  = 2;
  localparam int unsigned PIPE_DATA_W_DEF = 160;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    PIPE_ST_EMPTY = 2'd0,
    PIPE_ST_ONE   = 2'd1,
    PIPE_ST_TWO   = 2'd2
  } pipe_st_e;

endpackage

// File: rtl/pipe_stage_buf_bundle_reg.sv
// LANES x DATA_W bundle register with load enable and sync clear; invalid lanes load as all-zero NOPs.
module pipe_bundle_reg
  import pipe_stage_buf_pkg::*;
#(
  parameter int unsigned LANES  = PIPE_LANES_DEF,
  parameter int unsigned DATA_W = PIPE_DATA_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_clr,
  input  logic                      i_load,
  input  logic [LANES-1:0]          i_valid,
  input  logic [LANES*DATA_W-1:0]   i_data,
  output logic [LANES-1:0]          o_valid,
  output logic [LANES*DATA_W-1:0]   o_data
);

  logic [LANES-1:0]        r_valid;
  logic [LANES*DATA_W-1:0] r_data;
  logic [LANES*DATA_W-1:0] w_fill;

  always_comb begin
    w_fill = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (i_valid[i]) w_fill[i*DATA_W +: DATA_W] = i_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_data  <= '0;
    end else if (i_clr) begin
      r_valid <= '0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= i_valid;
      r_data  <= w_fill;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_buf.sv
// Two-entry skid-buffered pipeline stage register carrying a LANES-wide issue bundle.
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int unsigned LANES  = PIPE_LANES_DEF,
  parameter int unsigned DATA_W = PIPE_DATA_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [LANES-1:0]          up_valid,
  input  logic [LANES*DATA_W-1:0]   up_data,
  output logic                      up_ready,
  output logic [LANES-1:0]          down_valid,
  output logic [LANES*DATA_W-1:0]   down_data,
  input  logic                      down_ready,
  output logic [1:0]                occupancy
);

  pipe_st_e r_state;
  pipe_st_e w_state_nxt;
  logic     r_up_ready;

  logic w_up_fire;
  logic w_down_fire;
  logic w_main_clr;
  logic w_main_load;
  logic w_main_from_skid;
  logic w_skid_clr;
  logic w_skid_load;

  logic [LANES-1:0]        w_skid_valid;
  logic [LANES*DATA_W-1:0] w_skid_data;
  logic [LANES-1:0]        w_main_valid_in;
  logic [LANES*DATA_W-1:0] w_main_data_in;

  assign w_up_fire   = r_up_ready & (|up_valid) & ~flush;
  assign w_down_fire = down_ready & (|down_valid);

  // up_ready is registered from the next state, so it never depends on down_ready combinationally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= PIPE_ST_EMPTY;
      r_up_ready <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_up_ready <= (w_state_nxt != PIPE_ST_TWO);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = PIPE_ST_EMPTY;
    end else begin
      case (r_state)
        PIPE_ST_EMPTY: if (w_up_fire) w_state_nxt = PIPE_ST_ONE;
        PIPE_ST_ONE: begin
          if (w_up_fire && !w_down_fire)      w_state_nxt = PIPE_ST_TWO;
          else if (!w_up_fire && w_down_fire) w_state_nxt = PIPE_ST_EMPTY;
        end
        PIPE_ST_TWO:   if (w_down_fire) w_state_nxt = PIPE_ST_ONE;
        default:       w_state_nxt = PIPE_ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    w_main_clr       = flush;
    w_main_load      = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_clr       = flush;
    w_skid_load      = 1'b0;
    if (!flush) begin
      case (r_state)
        PIPE_ST_EMPTY: w_main_load = w_up_fire;
        PIPE_ST_ONE: begin
          if (w_up_fire && w_down_fire) w_main_load = 1'b1;
          else if (w_up_fire)           w_skid_load = 1'b1;
          else if (w_down_fire)         w_main_clr  = 1'b1;
        end
        PIPE_ST_TWO: begin
          if (w_down_fire) begin
            w_main_load      = 1'b1;
            w_main_from_skid = 1'b1;
            w_skid_clr       = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_main_valid_in = w_main_from_skid ? w_skid_valid : up_valid;
  assign w_main_data_in  = w_main_from_skid ? w_skid_data  : up_data;

  pipe_bundle_reg #(.LANES(LANES), .DATA_W(DATA_W)) u_main (
    .clk     (clk),
    .rst_n   (rst),
    .i_clr   (w_main_clr),
    .i_load  (w_main_load),
    .i_valid (w_main_valid_in),
    .i_data  (w_main_data_in),
    .o_valid (down_valid),
    .o_data  (down_data)
  );

  pipe_bundle_reg #(.LANES(LANES), .DATA_W(DATA_W)) u_skid (
    .clk     (clk),
    .rst_n   (rst),
    .i_clr   (w_skid_clr),
    .i_load  (w_skid_load),
    .i_valid (up_valid),
    .i_data  (up_data),
    .o_valid (w_skid_valid),
    .o_data  (w_skid_data)
  );

  assign up_ready  = r_up_ready;
  assign occupancy = r_state;

endmodule
